// File: rtl/counter_up_dn_mod_if.sv
// Control and status bundle for counter_up_dn_mod. The master drives
// count controls; the slave (the counter) returns q, dir and tc.
interface counter_up_dn_mod_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             u_d;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lim;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             dir;
  logic             tc;

  modport master (
    output en, u_d, mode, lim, ld, d,
    input  q, dir, tc
  );

  modport slave (
    input  en, u_d, mode, lim, ld, d,
    output q, dir, tc
  );
endinterface

// File: rtl/counter_up_dn_mod.sv
// Up/down counter over 0..lim with wrap, saturate, bounce and hold modes,
// synchronous load and a registered terminal-count pulse for cascading.
module counter_up_dn_mod #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 r,
  counter_up_dn_mod_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t            mode_sel;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             dir_r, dir_nxt;
  logic             tc_r, tc_nxt;
  logic             step_up;
  logic             out_of_range;
  logic             boundary;

  assign mode_sel = mode_t'(bus.mode);

  // Bounce keeps its own direction; every other mode follows u_d directly.
  assign step_up      = (mode_sel == MODE_BOUNCE) ? dir_r : bus.u_d;
  assign out_of_range = (q_r > bus.lim);
  assign boundary     = !out_of_range &&
                        (step_up ? (q_r == bus.lim) : (q_r == '0));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    q_nxt   = q_r;
    dir_nxt = (mode_sel == MODE_BOUNCE) ? dir_r : bus.u_d;
    tc_nxt  = 1'b0;

    if (bus.ld) begin
      q_nxt   = (bus.d > bus.lim) ? bus.lim : bus.d;
      dir_nxt = bus.u_d;
    end else if (bus.en && (mode_sel != MODE_HOLD)) begin
      if (out_of_range) begin
        // lim was lowered beneath q: snap to the new ceiling, no pulse.
        q_nxt = bus.lim;
      end else if (!boundary) begin
        q_nxt = step_up ? (q_r + ONE) : (q_r - ONE);
      end else begin
        tc_nxt = 1'b1;
        case (mode_sel)
          MODE_WRAP: q_nxt = step_up ? '0 : bus.lim;
          MODE_SAT:  q_nxt = q_r;
          MODE_BOUNCE: begin
            dir_nxt = !dir_r;
            // With lim==0 there is nowhere to reflect to, so q stays 0.
            if (bus.lim == '0) begin
              q_nxt = '0;
            end else begin
              q_nxt = step_up ? (bus.lim - ONE) : ONE;
            end
          end
          default:   q_nxt = q_r;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!r) begin
      q_r   <= '0;
      dir_r <= 1'b1;
      tc_r  <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      dir_r <= dir_nxt;
      tc_r  <= tc_nxt;
    end
  end

  assign bus.q   = q_r;
  assign bus.dir = dir_r;
  assign bus.tc  = tc_r;

endmodule

// File: tb/tb_counter_up_dn_mod.sv
// Scoreboard bench for counter_up_dn_mod: directed scenarios then random
// traffic, each cycle's expected outputs come from an integer model.
module tb_counter_up_dn_mod;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  counter_up_dn_mod_if #(.WIDTH(WIDTH)) bus ();

  counter_up_dn_mod #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  typedef struct {
    int q;
    int dir;
    int tc;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference state, plain integers.
  int mq   = 0;
  int mdir = 1;
  int mtc  = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Behavioural model: wrap is modulo (lim+1), saturate clamps, bounce
  // reflects off the range ends.
  task automatic model(input bit rr, input bit ld, input bit en, input bit ud,
                       input int mode, input int lim, input int d);
    int s;
    int n;
    bit outside;
    if (!rr) begin
      mq = 0; mdir = 1; mtc = 0;
      return;
    end
    mtc = 0;
    if (ld) begin
      mq   = (d < lim) ? d : lim;
      mdir = ud;
      return;
    end
    if (mode != 2) mdir = ud;
    if (!en || mode == 3) return;
    if (mq > lim) begin
      mq = lim;
      return;
    end
    s       = mdir ? 1 : -1;
    n       = mq + s;
    outside = (n < 0) || (n > lim);
    case (mode)
      0: begin
        mtc = outside;
        mq  = (n + lim + 1) % (lim + 1);
      end
      1: begin
        if (outside) mtc = 1;
        else         mq  = n;
      end
      default: begin
        if (outside) begin
          mtc  = 1;
          mdir = !mdir;
          n    = mq - s;
          if (n >= 0 && n <= lim) mq = n;
        end else begin
          mq = n;
        end
      end
    endcase
  endtask

  task automatic drive(input bit rr, input bit ld, input bit en, input bit ud,
                       input int mode, input int lim, input int d);
    @(negedge clk);
    r        = rr;
    bus.ld   = ld;
    bus.en   = en;
    bus.u_d  = ud;
    bus.mode = 2'(mode);
    bus.lim  = WIDTH'(lim);
    bus.d    = WIDTH'(d);
    model(rr, ld, en, ud, mode, lim, d);
    step_no++;
    sb.push_back('{q: mq, dir: mdir, tc: mtc, idx: step_no});
  endtask

  // Monitor: the counter presents a new result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",   e.idx, 32'(bus.q),   32'(e.q));
        check("dir", e.idx, 32'(bus.dir), 32'(e.dir));
        check("tc",  e.idx, 32'(bus.tc),  32'(e.tc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c_mode, c_lim, c_ud;
    r = 1'b0; bus.ld = 1'b0; bus.en = 1'b0; bus.u_d = 1'b1;
    bus.mode = 2'b00; bus.lim = '0; bus.d = '0;

    // Reset, wrap up lim=9, then reset mid-count at q=5.
    repeat (2) drive(0, 0, 0, 1, 0, 9, 0);
    repeat (12) drive(1, 0, 1, 1, 0, 9, 0);
    repeat (3) drive(1, 0, 1, 1, 0, 9, 0);
    drive(0, 0, 1, 1, 0, 9, 0);

    // Wrap down from 0, then saturate from a load of 3.
    repeat (3) drive(1, 0, 1, 0, 0, 5, 0);
    drive(1, 1, 1, 1, 1, 5, 3);
    repeat (5) drive(1, 0, 1, 1, 1, 5, 0);

    // Bounce over 0..3.
    drive(1, 1, 1, 1, 2, 3, 0);
    repeat (10) drive(1, 0, 1, 1, 2, 3, 0);

    // Load clamp beats enable, then out-of-range recovery on lowered lim.
    drive(1, 1, 1, 1, 0, 7, 12);
    repeat (2) drive(1, 0, 1, 0, 0, 4, 0);

    // Hold, enable gating, load during hold.
    drive(1, 1, 0, 1, 0, 9, 6);
    repeat (3) drive(1, 0, 1, 1, 3, 9, 0);
    repeat (2) drive(1, 0, 0, 1, 0, 9, 0);
    drive(1, 1, 1, 1, 3, 9, 2);

    // Full range wrap and degenerate bounce.
    drive(1, 1, 0, 1, 0, MAXV, 14);
    repeat (3) drive(1, 0, 1, 1, 0, MAXV, 0);
    repeat (4) drive(1, 0, 1, 1, 2, 0, 0);
    repeat (3) drive(1, 0, 1, 0, 1, 0, 0);

    // Random traffic with sticky mode/limit/direction.
    c_mode = 0; c_lim = 9; c_ud = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5) c_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 8) begin
        case ($urandom_range(0, 3))
          0:       c_lim = 0;
          1:       c_lim = MAXV;
          default: c_lim = $urandom_range(0, MAXV);
        endcase
      end
      if ($urandom_range(0, 99) < 15) c_ud = $urandom_range(0, 1);
      drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 85), c_ud[0], c_mode, c_lim,
            $urandom_range(0, MAXV));
    end

    @(posedge clk);
    #2;
    check("drain", step_no, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
